nco_mc: RTL and testbench
=========================

# nco_mc

Multi-channel, time-multiplexed numerically controlled oscillator. It is the next-generation NCO of the DSP chain and has these properties:
- Parametrised channel count, accumulator width and table depth.
- One shared quarter-wave sine table.
- Per-channel frequency, phase offset and signed amplitude scale, written through a register port.
- Aligned sine, cosine and scaled-sine outputs tagged with a channel number.

It feeds the mixers and test-tone sources.

## Interface
Parameters:
- WAVE_WIDTH, 16, sample width; AMPLITUDE = 2^(WAVE_WIDTH-1)-1
- LUT_ADDR_BITS, 8, quarter-wave table depth N = 2^LUT_ADDR_BITS; full cycle 4N points
- NUM_CH, 4, number of channels (at least 2)
- ACC_WIDTH, 32, phase accumulator width (from LUT_ADDR_BITS+2 up to 32)
- SCALE_INT_WIDTH, 2, integer bits of the scale, sign included
- SCALE_Q_WIDTH, 14, fractional bits of the scale

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  issue one sample for the current channel this cycle
- sync  in  1  clear all accumulators and the channel counter
- cfg_we  in  1  configuration write strobe
- cfg_ch  in  clog2(NUM_CH)  channel being written
- cfg_sel  in  2  register select: 0 freq, 1 phase, 2 scale, 3 ignored
- cfg_data  in  32  write data; LSBs are used
- out_valid  out  1  output sample valid
- out_ch  out  clog2(NUM_CH)  channel of the output sample
- sine_out  out  WAVE_WIDTH  signed sine
- cos_out  out  WAVE_WIDTH  signed cosine
- scaled_sine_out  out  WAVE_WIDTH  signed, saturated sine × scale

## Operation
Per-channel registers:
- freq[c]: ACC_WIDTH bits, reset 0.
- phase[c]: LUT_ADDR_BITS+2 bits, reset 0.
- scale[c]: signed Q(SCALE_INT_WIDTH).(SCALE_Q_WIDTH), reset 0x4000 (unity).
- acc[c]: ACC_WIDTH bits, reset 0.

Channel counter ch:
- Reset value 0.
- Advances by 1 on every en cycle, wrapping NUM_CH-1 → 0.

On an en cycle, for channel ch:
- Phase index P = acc[ch][ACC_WIDTH-1 -: LUT_ADDR_BITS+2] + phase[ch], modulo 4N.
- The sample uses acc before the update; then acc[ch] += freq[ch], modulo 2^ACC_WIDTH.

Table:
- T[k] = round(AMPLITUDE · sin(π(2k+1)/(4N))) for k = 0..N-1.
- Built at elaboration; read through one registered read stage.

Quarter-wave reconstruction, with q = P[top 2 bits] and a = P[low LUT_ADDR_BITS bits]:
- sin: q0 → T[a]; q1 → T[N-1-a]; q2 → −T[a]; q3 → −T[N-1-a].
- cos(P) = sin(P+N).

Scaling:
- scaled = (sine · scale) >>> SCALE_Q_WIDTH, using an arithmetic (floor) shift.
- The result saturates to [−2^(WAVE_WIDTH-1), AMPLITUDE].

Configuration writes:
- A write is applied at the clock edge of the cfg_we cycle.
- An en cycle that coincides with a write uses the old value. A write of phase or scale affects only samples issued later.

sync:
- Clears every acc[c] and ch to 0.
- No sample is issued in a sync cycle, even if en is high.
- Samples already in the pipeline still drain. Configuration registers are kept.

rst:
- Returns every register to its reset value and flushes the pipeline.
- Output reset values: out_valid 0, out_ch 0, sine_out 0, cos_out 0, scaled_sine_out 0.

## Timing
- Four-stage pipeline:
  - S1: capture P and ch.
  - S2: table read.
  - S3: apply sign; sine and cos ready.
  - S4: multiply, shift, saturate.
- All outputs are registered and aligned. out_valid, out_ch and all three samples come from the same issue.
- An en sampled high at edge t gives out_valid=1 after edge t+4.
- Throughput is one sample per cycle. There is no backpressure.
- When out_valid=0, the data outputs hold their last values.
- Reset mid-stream: out_valid is 0 from the first edge with rst=1. No sample issued before the reset is ever emitted.

## Test plan
Defaults: WAVE_WIDTH 16, LUT_ADDR_BITS 8 (N=256), NUM_CH 4, ACC_WIDTH 32. Known table values: T[0]=101, T[1]=302, T[255]=32767.

1. Reset, then en held high, all freq=0 and phase=0 → first out_valid 4 cycles after en; out_ch runs 0,1,2,3,0,…; every sample is sine=101, cos=32767, scaled=101.
2. phase[1]=256 → channel 1 gives sine=32767, cos=−101. phase[2]=768 → channel 2 gives sine=−32767, cos=101.
3. freq[0]=2^22, en continuous → successive channel-0 samples have P=0,1,2,… with sine 101, 302, …; after 1024 channel-0 samples P wraps to 0 and sine returns to 101.
4. Channel 1 at phase 256 with three scale settings:
   - scale 0x2000 → scaled=16383.
   - scale 0x7FFF → scaled saturates to 32767.
   - phase 768 with scale 0x7FFF → scaled=−32768.
   - scale 0xC000 (−1.0) at phase 256 → scaled=−32767.
5. Same-cycle events with freq[0]=2^22:
   - A cfg write to phase[0] in the same cycle as a channel-0 en → that sample uses the old phase; the next channel-0 sample uses the new one.
   - sync together with en → no sample issued; the next en issues channel 0 with P=phase[0].
6. Assert rst while samples are in flight → out_valid is 0 from the next edge, with no stale samples emitted. freq, phase and scale return to 0, 0 and 0x4000.

Source files
------------

// File: rtl/nco_mc.sv
// Time-multiplexed multi-channel NCO: per-channel phase accumulators share one
// quarter-wave sine table and produce aligned sine, cosine and scaled sine.
module nco_mc #(
  parameter int unsigned WAVE_WIDTH      = 16,
  parameter int unsigned LUT_ADDR_BITS   = 8,
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned ACC_WIDTH       = 32,
  parameter int unsigned SCALE_INT_WIDTH = 2,
  parameter int unsigned SCALE_Q_WIDTH   = 14
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic                              sync,
  input  logic                              cfg_we,
  input  logic [$clog2(NUM_CH)-1:0]         cfg_ch,
  input  logic [1:0]                        cfg_sel,
  input  logic [31:0]                       cfg_data,
  output logic                              out_valid,
  output logic [$clog2(NUM_CH)-1:0]         out_ch,
  output logic signed [WAVE_WIDTH-1:0]      sine_out,
  output logic signed [WAVE_WIDTH-1:0]      cos_out,
  output logic signed [WAVE_WIDTH-1:0]      scaled_sine_out
);

  localparam int unsigned N         = 1 << LUT_ADDR_BITS;
  localparam int unsigned PW        = LUT_ADDR_BITS + 2;
  localparam int unsigned CH_W      = $clog2(NUM_CH);
  localparam int unsigned SCW       = SCALE_INT_WIDTH + SCALE_Q_WIDTH;
  localparam int unsigned PRW       = WAVE_WIDTH + SCW;
  localparam int unsigned SHW       = PRW - SCALE_Q_WIDTH;
  localparam int unsigned AMPLITUDE = (1 << (WAVE_WIDTH - 1)) - 1;

  localparam logic signed [SHW-1:0] SAT_HI = SHW'(AMPLITUDE);
  localparam logic signed [SHW-1:0] SAT_LO = ~SAT_HI;
  localparam logic [SCW-1:0]        SCALE_ONE = SCW'(1 << SCALE_Q_WIDTH);

  // Rounded quarter-wave sample k, evaluated at elaboration only.
  function automatic int lut_val(input int k);
    real pi_r;
    real ang;
    pi_r = 3.14159265358979323846;
    ang  = pi_r * real'(2 * k + 1) / real'(4 * N);
    return $rtoi(real'(AMPLITUDE) * $sin(ang) + 0.5);
  endfunction

  logic [WAVE_WIDTH-1:0] lut [N];

  for (genvar k = 0; k < N; k++) begin : g_lut
    localparam logic [WAVE_WIDTH-1:0] V = WAVE_WIDTH'(lut_val(k));
    assign lut[k] = V;
  end

  logic [ACC_WIDTH-1:0] freq  [NUM_CH];
  logic [PW-1:0]        phase [NUM_CH];
  logic [SCW-1:0]       scale [NUM_CH];
  logic [ACC_WIDTH-1:0] acc   [NUM_CH];
  logic [CH_W-1:0]      ch;

  logic                 issue_c;
  logic [PW-1:0]        p_c;

  assign issue_c = en & ~sync;
  assign p_c     = acc[ch][ACC_WIDTH-1 -: PW] + phase[ch];

  // Configuration registers, accumulators and the channel counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        freq[c]  <= '0;
        phase[c] <= '0;
        scale[c] <= SCALE_ONE;
        acc[c]   <= '0;
      end
      ch <= '0;
    end else begin
      if (cfg_we) begin
        case (cfg_sel)
          2'd0:    freq[cfg_ch]  <= cfg_data[ACC_WIDTH-1:0];
          2'd1:    phase[cfg_ch] <= cfg_data[PW-1:0];
          2'd2:    scale[cfg_ch] <= cfg_data[SCW-1:0];
          default: ;
        endcase
      end
      if (sync) begin
        for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
        ch <= '0;
      end else if (issue_c) begin
        acc[ch] <= acc[ch] + freq[ch];
        ch      <= (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + CH_W'(1);
      end
    end
  end

  // Pipeline registers.
  logic                        s1_valid, s2_valid, s3_valid, s4_valid;
  logic [CH_W-1:0]             s1_ch, s2_ch, s3_ch, s4_ch;
  logic [PW-1:0]               s1_p;
  logic [SCW-1:0]              s1_scale, s2_scale;
  logic [WAVE_WIDTH-1:0]       s2_sin, s2_cos;
  logic                        s2_sneg, s2_cneg;
  logic signed [WAVE_WIDTH-1:0] s3_sine, s3_cos, s4_sine, s4_cos;
  logic signed [SCW-1:0]       s3_scale;
  logic signed [SHW-1:0]       s4_prod;

  logic [PW-1:0]               pc_c;
  logic [LUT_ADDR_BITS-1:0]    a_c, sin_addr_c, cos_addr_c;
  logic signed [PRW-1:0]       prod_c;
  logic signed [WAVE_WIDTH-1:0] sat_c;

  // Quarter-wave folding: odd quadrants mirror the address, upper half negates.
  always_comb begin
    pc_c       = s1_p + PW'(N);
    a_c        = s1_p[LUT_ADDR_BITS-1:0];
    sin_addr_c = s1_p[LUT_ADDR_BITS] ? ~a_c : a_c;
    cos_addr_c = pc_c[LUT_ADDR_BITS] ? ~a_c : a_c;
    prod_c     = PRW'(s3_sine) * PRW'(s3_scale);
    if (s4_prod > SAT_HI)      sat_c = WAVE_WIDTH'(SAT_HI);
    else if (s4_prod < SAT_LO) sat_c = WAVE_WIDTH'(SAT_LO);
    else                       sat_c = WAVE_WIDTH'(s4_prod);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0; s2_valid <= 1'b0; s3_valid <= 1'b0; s4_valid <= 1'b0;
      s1_ch <= '0; s2_ch <= '0; s3_ch <= '0; s4_ch <= '0;
      s1_p <= '0; s1_scale <= '0; s2_scale <= '0;
      s2_sin <= '0; s2_cos <= '0; s2_sneg <= 1'b0; s2_cneg <= 1'b0;
      s3_sine <= '0; s3_cos <= '0; s3_scale <= '0;
      s4_sine <= '0; s4_cos <= '0; s4_prod <= '0;
      out_valid <= 1'b0; out_ch <= '0;
      sine_out <= '0; cos_out <= '0; scaled_sine_out <= '0;
    end else begin
      s1_valid <= issue_c;
      s1_ch    <= ch;
      s1_p     <= p_c;
      s1_scale <= scale[ch];

      s2_valid <= s1_valid;
      s2_ch    <= s1_ch;
      s2_sin   <= lut[sin_addr_c];
      s2_cos   <= lut[cos_addr_c];
      s2_sneg  <= s1_p[PW-1];
      s2_cneg  <= pc_c[PW-1];
      s2_scale <= s1_scale;

      s3_valid <= s2_valid;
      s3_ch    <= s2_ch;
      s3_sine  <= s2_sneg ? -$signed(s2_sin) : $signed(s2_sin);
      s3_cos   <= s2_cneg ? -$signed(s2_cos) : $signed(s2_cos);
      s3_scale <= $signed(s2_scale);

      s4_valid <= s3_valid;
      s4_ch    <= s3_ch;
      s4_sine  <= s3_sine;
      s4_cos   <= s3_cos;
      s4_prod  <= prod_c[PRW-1:SCALE_Q_WIDTH];

      out_valid <= s4_valid;
      if (s4_valid) begin
        out_ch          <= s4_ch;
        sine_out        <= s4_sine;
        cos_out         <= s4_cos;
        scaled_sine_out <= sat_c;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{cfg_data, prod_c[SCALE_Q_WIDTH-1:0]};

endmodule

// File: tb/tb_nco_mc.sv
// Directed self-checking bench for nco_mc with hand-computed expected samples.
module tb_nco_mc;

  logic        clk = 1'b0;
  logic        rst, en, sync, cfg_we;
  logic [1:0]  cfg_ch, cfg_sel;
  logic [31:0] cfg_data;
  logic        out_valid;
  logic [1:0]  out_ch;
  logic signed [15:0] sine_out, cos_out, scaled_sine_out;

  int errors = 0;
  int checks = 0;

  nco_mc dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .out_valid(out_valid), .out_ch(out_ch), .sine_out(sine_out),
    .cos_out(cos_out), .scaled_sine_out(scaled_sine_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input int c, input int sel, input logic [31:0] d);
    cfg_we = 1'b1; cfg_ch = 2'(c); cfg_sel = 2'(sel); cfg_data = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic do_sync();
    sync = 1'b1; step(); sync = 1'b0;
  endtask

  task automatic burst(input int n);
    en = 1'b1; repeat (n) step(); en = 1'b0;
  endtask

  // Waits (bounded) for the next valid sample, checks it, then moves one cycle on.
  task automatic expect_out(input string tag, input int c, input int s, input int co, input int sc);
    int n = 0;
    while (!out_valid && n < 12) begin step(); n++; end
    chk({tag, "_valid"}, int'(out_valid), 1);
    chk({tag, "_ch"}, int'(out_ch), c);
    chk({tag, "_sin"}, int'(sine_out), s);
    chk({tag, "_cos"}, int'(cos_out), co);
    chk({tag, "_scl"}, int'(scaled_sine_out), sc);
    step();
  endtask

  initial begin
    int gaps;
    int n;
    rst = 1'b1; en = 1'b0; sync = 1'b0; cfg_we = 1'b0;
    cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
    repeat (3) step();
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_ch", int'(out_ch), 0);
    chk("rst_sin", int'(sine_out), 0);
    chk("rst_cos", int'(cos_out), 0);
    chk("rst_scl", int'(scaled_sine_out), 0);
    rst = 1'b0;
    step();

    // Latency and channel rotation with zero freq/phase.
    en = 1'b1;
    repeat (4) step();
    chk("lat_early", int'(out_valid), 0);
    step();
    chk("lat_valid", int'(out_valid), 1);
    expect_out("t1_c0", 0, 101, 32767, 101);
    expect_out("t1_c1", 1, 101, 32767, 101);
    expect_out("t1_c2", 2, 101, 32767, 101);
    expect_out("t1_c3", 3, 101, 32767, 101);
    expect_out("t1_c0b", 0, 101, 32767, 101);
    en = 1'b0;
    repeat (8) step();

    // Phase offsets of a quarter and three quarters of a cycle.
    cfg_write(1, 1, 32'd256);
    cfg_write(2, 1, 32'd768);
    do_sync();
    burst(3);
    expect_out("t2_c0", 0, 101, 32767, 101);
    expect_out("t2_c1", 1, 32767, -101, 32767);
    expect_out("t2_c2", 2, -32767, 101, -32767);
    repeat (4) step();
    chk("hold_valid", int'(out_valid), 0);
    chk("hold_sin", int'(sine_out), -32767);

    // Channel 0 sweeps the table one point per sample and wraps after 1024.
    cfg_write(0, 0, 32'h0040_0000);
    do_sync();
    en = 1'b1;
    n = 0;
    while (!out_valid && n < 12) begin step(); n++; end
    gaps = 0;
    for (int i = 0; i < 4100; i++) begin
      if (!out_valid) gaps++;
      if (i == 0)    begin chk("t3_p0_ch", int'(out_ch), 0); chk("t3_p0", int'(sine_out), 101); end
      if (i == 4)    begin chk("t3_p1_ch", int'(out_ch), 0); chk("t3_p1", int'(sine_out), 302); end
      if (i == 4096) begin chk("t3_wrap_ch", int'(out_ch), 0); chk("t3_wrap", int'(sine_out), 101); end
      step();
    end
    chk("t3_gaps", gaps, 0);
    en = 1'b0;
    repeat (8) step();

    // Scale on channel 1.
    cfg_write(1, 2, 32'h2000);
    do_sync(); burst(2);
    expect_out("t4a_c0", 0, 101, 32767, 101);
    expect_out("t4a_c1", 1, 32767, -101, 16383);
    cfg_write(1, 2, 32'h7FFF);
    do_sync(); burst(2);
    expect_out("t4b_c0", 0, 101, 32767, 101);
    expect_out("t4b_c1", 1, 32767, -101, 32767);
    cfg_write(1, 1, 32'd768);
    do_sync(); burst(2);
    expect_out("t4c_c0", 0, 101, 32767, 101);
    expect_out("t4c_c1", 1, -32767, 101, -32768);
    cfg_write(1, 1, 32'd256);
    cfg_write(1, 2, 32'hC000);
    do_sync(); burst(2);
    expect_out("t4d_c0", 0, 101, 32767, 101);
    expect_out("t4d_c1", 1, 32767, -101, -32767);

    // Phase write coinciding with a channel-0 issue takes effect next time round.
    do_sync();
    en = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_sel = 2'd1; cfg_data = 32'd255;
    step();
    cfg_we = 1'b0;
    repeat (4) step();
    en = 1'b0;
    expect_out("t5a_c0", 0, 101, 32767, 101);
    expect_out("t5a_c1", 1, 32767, -101, -32767);
    expect_out("t5a_c2", 2, -32767, 101, -32767);
    expect_out("t5a_c3", 3, 101, 32767, 101);
    expect_out("t5a_c0n", 0, 32767, -101, 32767);
    repeat (6) step();

    // sync together with en issues nothing; the following en starts at channel 0.
    sync = 1'b1; en = 1'b1;
    step();
    sync = 1'b0;
    step();
    en = 1'b0;
    expect_out("t5b_c0", 0, 32767, 101, 32767);
    chk("t5b_single", int'(out_valid), 0);
    repeat (6) step();

    // Reset with samples in flight.
    en = 1'b1;
    repeat (2) step();
    rst = 1'b1; en = 1'b0;
    step();
    chk("t6_valid", int'(out_valid), 0);
    chk("t6_sin", int'(sine_out), 0);
    rst = 1'b0;
    gaps = 0;
    repeat (8) begin step(); if (out_valid) gaps++; end
    chk("t6_stale", gaps, 0);
    burst(5);
    expect_out("t6_c0", 0, 101, 32767, 101);
    expect_out("t6_c1", 1, 101, 32767, 101);
    expect_out("t6_c2", 2, 101, 32767, 101);
    expect_out("t6_c3", 3, 101, 32767, 101);
    expect_out("t6_c0b", 0, 101, 32767, 101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
